// File: rtl/queen_solution_buffer.sv
// -----------------------------------------------------------------------------
// queen_solution_buffer
//
// Buffers solved 8-queen boards between the solver's row stream and a
// (possibly slow) consumer. Each board is eight one-hot row bytes. A board
// becomes visible to the read side only after all eight rows are written.
// The read side replays boards row by row over a valid/ready handshake.
//
// Parameters:
//   DEPTH           board slots, power of two, >= 2 (storage DEPTH*8 bytes)
//
// Ports:
//   clk             single clock, rising edge
//   reset           synchronous, active-high, clears all state
//   in_valid        solver presents a row byte
//   in_row[7:0]     one-hot row byte (bit k = queen in column k)
//   in_ready        a row can be accepted this cycle
//   out_valid       head board has a row available
//   out_row[7:0]    current row byte of the head board
//   out_index[2:0]  row number of out_row
//   out_last        out_index == 7 while out_valid
//   out_ready       consumer accepts out_row
//   solution_count  boards committed since reset, saturates at 127
//   full            all DEPTH slots hold committed boards
//   empty           no committed board
//   error           sticky malformed-row flag
//
// Optional feature macro: QUEEN_ROW_CHECK_EN
//   Defined   : every accepted row must be one-hot; a bad row sets `error`
//               and the board it belongs to is dropped at its row-7 accept.
//   Undefined : no row check, `error` tied low, every full board commits.
// -----------------------------------------------------------------------------
module queen_solution_buffer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_row,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_row,
  output logic [2:0] out_index,
  output logic       out_last,
  input  logic       out_ready,
  output logic [6:0] solution_count,
  output logic       full,
  output logic       empty,
  output logic       error
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  // Storage is addressed as {slot, row}, so each slot holds exactly 8 rows.
  logic [7:0]    mem [DEPTH*8];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic [2:0]    wr_idx;
  logic [2:0]    rd_idx;
  logic [6:0]    sol_cnt;

  logic          wr_fire;
  logic          rd_fire;
  logic          board_ok;
  logic          commit;
  logic          pop;

  // Flow control depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count != CNT_DEPTH);
  assign full      = (count == CNT_DEPTH);
  assign empty     = (count == '0);
  assign out_valid = !empty;

  assign wr_fire = in_valid && in_ready;
  assign rd_fire = out_valid && out_ready;

  assign commit = wr_fire && (wr_idx == 3'd7) && board_ok;
  assign pop    = rd_fire && (rd_idx == 3'd7);

  // Read data is a direct view of storage; forced to zero when nothing is
  // buffered so the idle/reset value is defined even though storage is not.
  assign out_row   = out_valid ? mem[{head, rd_idx}] : 8'h00;
  assign out_index = rd_idx;
  assign out_last  = out_valid && (rd_idx == 3'd7);

  assign solution_count = sol_cnt;

`ifdef QUEEN_ROW_CHECK_EN
  logic row_ok;
  logic bad_board;
  logic error_q;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign row_ok   = (in_row != 8'h00) && ((in_row & (in_row - 8'd1)) == 8'h00);
  // The row-7 byte itself is checked as well as any earlier row.
  assign board_ok = row_ok && !bad_board;
  assign error    = error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bad_board <= 1'b0;
      error_q   <= 1'b0;
    end else if (wr_fire) begin
      if (!row_ok) begin
        error_q <= 1'b1;
      end
      // The bad mark lives only until the board's last row; the slot is reused.
      if (wr_idx == 3'd7) begin
        bad_board <= 1'b0;
      end else if (!row_ok) begin
        bad_board <= 1'b1;
      end
    end
  end
`else
  assign board_ok = 1'b1;
  assign error    = 1'b0;
`endif

  // NOTE: the board storage is deliberately not reset; occupancy is tracked by
  // count/pointers and out_row is masked while empty, so stale bytes never leak.
  always_ff @(posedge clk) begin
    if (!reset && wr_fire) begin
      mem[{tail, wr_idx}] <= in_row;
    end
  end

  // NOTE: all registered state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      wr_idx  <= 3'd0;
      rd_idx  <= 3'd0;
      sol_cnt <= 7'd0;
    end else begin
      // wr_idx wraps 7->0 naturally; a dropped board also restarts at row 0.
      if (wr_fire) begin
        wr_idx <= wr_idx + 3'd1;
      end
      if (commit) begin
        tail <= tail + PTR_ONE;
        if (sol_cnt != 7'd127) begin
          sol_cnt <= sol_cnt + 7'd1;
        end
      end

      if (rd_fire) begin
        rd_idx <= rd_idx + 3'd1;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end

      // Commit and pop on the same edge cancel out in the occupancy count.
      case ({commit, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_queen_solution_buffer.sv
// -----------------------------------------------------------------------------
// tb_queen_solution_buffer
//
// Self-checking bench for queen_solution_buffer (DEPTH = 4). A negedge model
// tracks accepted rows, pushes each completed (and, with QUEEN_ROW_CHECK_EN,
// well-formed) board into an expected-row queue, and every read handshake is
// popped and compared. Scenario tasks add their own direct checks.
// -----------------------------------------------------------------------------
module tb_queen_solution_buffer;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] row;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_row = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_row;
  logic [2:0] out_index;
  logic       out_last;
  logic       out_ready = 1'b0;
  logic [6:0] solution_count;
  logic       full;
  logic       empty;
  logic       error;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t       exp_q[$];
  logic [7:0] part [8];
  int         wm    = 0;
  logic       bad_m = 1'b0;

  logic [7:0] sol0 [8] = '{8'h01, 8'h10, 8'h80, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};

  queen_solution_buffer #(.DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_row         (in_row),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_row        (out_row),
    .out_index      (out_index),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .solution_count (solution_count),
    .full           (full),
    .empty          (empty),
    .error          (error)
  );

  always #5 clk = ~clk;

  // Distinct boards: rotations of one known solution.
  function automatic logic [7:0] brow(input int k, input int r);
    return sol0[(r + k) % 8];
  endfunction

  // Scoreboard: inputs are stable from posedge+1 to the next posedge, so a
  // handshake visible at negedge is the one taken at the following edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      wm    = 0;
      bad_m = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard_underflow: got row %h idx %0d, expected no output", out_row, out_index);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({out_index, out_row, out_last} !== {e.idx, e.row, (e.idx == 3'd7)})
            $display("FAIL scoreboard_row: got idx %0d row %h last %b, expected idx %0d row %h last %b",
                     out_index, out_row, out_last, e.idx, e.row, (e.idx == 3'd7));
          else
            n_pass++;
        end
      end
      if (in_valid && in_ready) begin
        part[wm] = in_row;
`ifdef QUEEN_ROW_CHECK_EN
        if ($countones(in_row) != 1) bad_m = 1'b1;
`endif
        if (wm == 7) begin
          if (!bad_m) begin
            for (int i = 0; i < 8; i++) exp_q.push_back('{idx: 3'(i), row: part[i]});
          end
          bad_m = 1'b0;
          wm    = 0;
        end else begin
          wm++;
        end
      end
    end
  end

  // Entered and left at posedge+1; leaves in_valid high so rows can be back to back.
  task automatic send_row(input logic [7:0] r);
    int guard = 0;
    in_valid = 1'b1;
    in_row   = r;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_row_timeout: in_ready got %b, expected 1 within 100 cycles", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    do_reset();
    n_checks++;
    if ({in_ready, out_valid, out_row, out_index, out_last, solution_count, full, empty, error}
        !== {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_state: rdy %b ov %b row %h idx %0d last %b cnt %0d full %b empty %b err %b, expected 1 0 00 0 0 0 0 1 0",
               in_ready, out_valid, out_row, out_index, out_last, solution_count, full, empty, error);
    else n_pass++;
  endtask

  task automatic test_single_board();
    do_reset();
    out_ready = 1'b1;
    for (int r = 0; r < 7; r++) send_row(sol0[r]);
    in_valid = 1'b1;
    in_row   = sol0[7];
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL single_before_commit: out_valid got %b, expected 0", out_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_index, out_row} !== {1'b1, 3'd0, 8'h01})
      $display("FAIL single_first_row: valid %b idx %0d row %h, expected 1 0 01", out_valid, out_index, out_row);
    else n_pass++;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if ({empty, out_valid, solution_count} !== {1'b1, 1'b0, 7'd1})
      $display("FAIL single_after_drain: empty %b valid %b count %0d, expected 1 0 1", empty, out_valid, solution_count);
    else n_pass++;
  endtask

  task automatic test_fill_backpressure();
    int guard;
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 8; r++) send_row(brow(k, r));
    in_valid = 1'b0;
    n_checks++;
    if ({full, in_ready, out_valid, solution_count} !== {1'b1, 1'b0, 1'b1, 7'd4})
      $display("FAIL fill_full: full %b rdy %b valid %b count %0d, expected 1 0 1 4", full, in_ready, out_valid, solution_count);
    else n_pass++;
    in_valid = 1'b1;
    in_row   = brow(4, 0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, full, solution_count} !== {1'b0, 1'b1, 7'd4})
      $display("FAIL fill_held_off: rdy %b full %b count %0d, expected 0 1 4", in_ready, full, solution_count);
    else n_pass++;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, full} !== {1'b1, 1'b0})
      $display("FAIL fill_reenable: rdy %b full %b, expected 1 0", in_ready, full);
    else n_pass++;
    for (int r = 0; r < 8; r++) send_row(brow(4, r));
    in_valid = 1'b0;
    n_checks++;
    if ({solution_count, full} !== {7'd5, 1'b1})
      $display("FAIL fill_board5: count %0d full %b, expected 5 1", solution_count, full);
    else n_pass++;
    out_ready = 1'b1;
    guard = 0;
    while (!empty && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    out_ready = 1'b0;
    n_checks++;
    if ({empty, out_valid} !== {1'b1, 1'b0})
      $display("FAIL fill_drain: empty %b valid %b, expected 1 0", empty, out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 5; k < 7; k++)
      for (int r = 0; r < 8; r++) send_row(brow(k, r));
    in_valid = 1'b0;
    // Start read of board 5 and write of board 7 on the same edge, so their
    // row-7 handshakes coincide.
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) send_row(brow(7, r));
    in_valid = 1'b0;
    n_checks++;
    if ({empty, full, solution_count, out_index, out_row} !== {1'b0, 1'b0, 7'd3, 3'd0, brow(6, 0)})
      $display("FAIL b2b_after_overlap: empty %b full %b count %0d idx %0d row %h, expected 0 0 3 0 %h",
               empty, full, solution_count, out_index, out_row, brow(6, 0));
    else n_pass++;
    repeat (15) @(posedge clk);
    #1;
    n_checks++;
    if ({empty, out_last} !== {1'b0, 1'b1})
      $display("FAIL b2b_15_pops: empty %b last %b, expected 0 1", empty, out_last);
    else n_pass++;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (empty !== 1'b1) $display("FAIL b2b_16_pops: empty got %b, expected 1", empty);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic       pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] saved_row = 8'h00;
    logic [2:0] saved_idx = 3'd0;
    logic       prev_stall = 1'b0;
    do_reset();
    for (int r = 0; r < 8; r++) send_row(brow(1, r));
    in_valid = 1'b0;
    for (int c = 0; c < 40 && !empty; c++) begin
      out_ready = pat[c % 4];
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if ({out_row, out_index} !== {saved_row, saved_idx})
          $display("FAIL stall_stable: row %h idx %0d, expected %h %0d", out_row, out_index, saved_row, saved_idx);
        else n_pass++;
      end
      saved_row  = out_row;
      saved_idx  = out_index;
      prev_stall = out_valid && !out_ready;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    n_checks++;
    if (empty !== 1'b1) $display("FAIL stall_drained: empty got %b, expected 1", empty);
    else n_pass++;
  endtask

  task automatic test_reset_mid_board();
    do_reset();
    for (int r = 0; r < 8; r++) send_row(brow(2, r));
    for (int r = 0; r < 3; r++) send_row(brow(3, r));
    in_valid = 1'b0;
    n_checks++;
    if (solution_count !== 7'd1) $display("FAIL midrst_before: count got %0d, expected 1", solution_count);
    else n_pass++;
    do_reset();
    n_checks++;
    if ({empty, solution_count, out_valid, in_ready} !== {1'b1, 7'd0, 1'b0, 1'b1})
      $display("FAIL midrst_after: empty %b count %0d valid %b rdy %b, expected 1 0 0 1",
               empty, solution_count, out_valid, in_ready);
    else n_pass++;
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) send_row(brow(4, r));
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_index, out_row} !== {1'b1, 3'd0, brow(4, 0)})
      $display("FAIL midrst_fresh: valid %b idx %0d row %h, expected 1 0 %h", out_valid, out_index, out_row, brow(4, 0));
    else n_pass++;
    repeat (8) @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if ({solution_count, empty} !== {7'd1, 1'b1})
      $display("FAIL midrst_drain: count %0d empty %b, expected 1 1", solution_count, empty);
    else n_pass++;
  endtask

  task automatic test_row_check();
    do_reset();
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) send_row((r == 3) ? 8'h03 : brow(0, r));
    in_valid = 1'b0;
    @(posedge clk);
    #1;
`ifdef QUEEN_ROW_CHECK_EN
    n_checks++;
    if ({error, solution_count, empty} !== {1'b1, 7'd0, 1'b1})
      $display("FAIL rowchk_bad_board: err %b count %0d empty %b, expected 1 0 1", error, solution_count, empty);
    else n_pass++;
`else
    n_checks++;
    if ({error, solution_count} !== {1'b0, 7'd1})
      $display("FAIL rowchk_disabled: err %b count %0d, expected 0 1", error, solution_count);
    else n_pass++;
`endif
    for (int r = 0; r < 8; r++) send_row(brow(5, r));
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    out_ready = 1'b0;
`ifdef QUEEN_ROW_CHECK_EN
    n_checks++;
    if ({error, solution_count, empty} !== {1'b1, 7'd1, 1'b1})
      $display("FAIL rowchk_good_board: err %b count %0d empty %b, expected 1 1 1", error, solution_count, empty);
    else n_pass++;
`else
    n_checks++;
    if ({error, solution_count, empty} !== {1'b0, 7'd2, 1'b1})
      $display("FAIL rowchk_good_board: err %b count %0d empty %b, expected 0 2 1", error, solution_count, empty);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_single_board();
    test_fill_backpressure();
    test_back_to_back();
    test_stall();
    test_reset_mid_board();
    test_row_check();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: %0d rows never delivered, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/queen_solution_buffer.md
# queen_solution_buffer

Downstream of the 8-queen datapath's `out_bus`. Collects the eight one-hot row bytes of each solved board into a FIFO of whole boards. Replays each board row-by-row over a valid/ready interface. Keeps a count of committed solutions, so the solver can keep searching while a slow consumer drains results.

## Interface
Parameters:
- `DEPTH`, default 4: board slots in the FIFO. Power of two, minimum 2. Storage is DEPTH×8 bytes.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `in_valid`  in  1  row byte presented by the solver (driven with `enable_output`).
- `in_row`  in  8  one-hot row byte; bit k = queen in column k.
- `in_ready`  out  1  buffer can accept a row this cycle.
- `out_valid`  out  1  head board has a row available.
- `out_row`  out  8  current row byte of head board.
- `out_index`  out  3  row number (0–7) of `out_row`.
- `out_last`  out  1  `out_index`==7 while `out_valid`.
- `out_ready`  in  1  consumer accepts `out_row`.
- `solution_count`  out  7  boards committed since reset; saturates at 127.
- `full`  out  1  all DEPTH slots committed.
- `empty`  out  1  no committed board.
- `error`  out  1  sticky malformed-row flag (see Configuration).

## Operation
- Write side:
  - A row is accepted on any edge where `in_valid && in_ready`.
  - It is stored at tail slot, row `wr_idx`, and `wr_idx` increments (wraps 7→0).
  - The accept with `wr_idx`==7 commits the board: tail advances, `count`+1, `solution_count`+1 (saturating).
- Write-side flow control:
  - `in_ready` = (`count` != DEPTH).
  - A partial board is never committed or visible.
  - `in_ready` depends only on registered state, never on `out_ready`.
- Read side:
  - `out_valid` = !`empty`.
  - `out_row`/`out_index` come from head slot, row `rd_idx`.
  - Each `out_valid && out_ready` increments `rd_idx`.
  - The handshake with `rd_idx`==7 pops the board: head advances, `count`−1, `rd_idx`→0.
- Simultaneous commit and pop on the same edge: `count` unchanged; both pointers advance.
- Commit while full is impossible, because `in_ready` is low.
- Pointers wrap modulo DEPTH.
- `count` is log2(DEPTH)+1 bits wide.
- `full` = (`count`==DEPTH); `empty` = (`count`==0).
- `out_row` holds stable while `out_valid && !out_ready`.
- Reset values, all outputs:
  - `in_ready`=1, `out_valid`=0, `out_row`=0, `out_index`=0, `out_last`=0
  - `solution_count`=0, `full`=0, `empty`=1, `error`=0
  - Pointers, `wr_idx` and `rd_idx` all 0.
- Reset mid-board: partial board is discarded and all buffered boards are lost; reset overrides any same-cycle handshake.

## Timing
- Write-to-read latency: the board commits at the edge accepting row 7. `out_valid` rises in the cycle after that edge, with row 0 presented.
- Throughput:
  - Write side accepts one row per cycle.
  - Read side delivers one row per cycle when `out_ready` is held high.
  - A board drains in 8 cycles.
- `out_row`, `out_index`, `out_last` are combinational reads of registered storage and indices, with no extra pipeline stage.
- `full`, `empty` and `in_ready` change only at clock edges.

## Configuration
- Macro: `QUEEN_ROW_CHECK_EN`.
- Defined:
  - Each accepted `in_row` is checked for exactly one set bit.
  - A failing row sets `error` (sticky until reset) and marks the board in progress bad.
  - At the row-7 accept, a bad board is dropped: no tail advance, `count` and `solution_count` unchanged, `wr_idx`→0. The slot is reused.
- Undefined:
  - No check; `error` is tied 0.
  - Every completed board commits.

## Test plan
- Single board:
  - Stimulus: after reset, write 0x01,0x10,0x80,0x20,0x04,0x40,0x02,0x08 on consecutive cycles, `out_ready`=1.
  - Response: `out_valid` rises one cycle after the last write; same 8 bytes out with `out_index` 0–7; `out_last` on 0x08; `solution_count`=1; `empty`=1 afterwards.
- Fill and backpressure:
  - Stimulus: DEPTH=4, `out_ready`=0, write 5 boards.
  - Response: `full`=1 and `in_ready`=0 after the 32nd row; the 33rd row is held off. Raising `out_ready` for 8 cycles re-enables `in_ready`, and board 5 then commits; `solution_count`=5.
- Simultaneous commit and pop:
  - Stimulus: `count`=2, row-7 write on the same edge as a row-7 read.
  - Response: `count` stays 2; the next board read is the correct FIFO order.
- Stall:
  - Stimulus: `out_ready` toggles 1,0,0,1.
  - Response: `out_row`/`out_index` stay stable during the 0 cycles; no rows are skipped or duplicated.
- Reset mid-board:
  - Stimulus: after 3 rows written and 1 board buffered, pulse `reset`.
  - Response: next cycle `empty`=1, `solution_count`=0, `out_valid`=0; a fresh board starts at `wr_idx` 0.
- Row check (`QUEEN_ROW_CHECK_EN`):
  - Stimulus: a board containing row 0x03.
  - Response: `error`=1; board not committed; `solution_count` unchanged; the following valid board commits normally.
